seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit frame from a multiplexed, active-low 7-segment scan.
// Digits are captured after STABLE_CYCLES stable samples; frame abandoned after TIMEOUT cycles.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 2000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] digits,
   output logic [3:0]  dp_o,
   output logic [3:0]  blank,
   output logic [3:0]  bad,
   output logic        frame_valid,
   output logic [7:0]  frame_count,
   output logic        timeout_err
);

   localparam int             TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW:0]    TLIM   = (TW + 1)'(TIMEOUT);
   localparam logic [7:0]     CAP_AT = 8'(STABLE_CYCLES - 2);

   typedef enum logic {WAIT, HELD} state_t;

   logic [7:0]    s_seg, p_seg;
   logic [3:0]    s_an, p_an;
   logic [7:0]    stab_cnt;
   state_t        state, state_nx;
   logic          same, capturable, capture;
   logic [1:0]    sel;
   logic [3:0]    code;
   logic          is_blank, is_bad;
   logic [3:0]    seen, new_bit;
   logic [15:0]   sh_digits;
   logic [3:0]    sh_dp, sh_blank, sh_bad;
   logic [TW-1:0] timer;
   logic [TW:0]   tmr_inc;
   logic          complete, cap_fills, expire;

   // p_* is the previous registered sample, used only for the stability compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_seg <= '0;
         s_an  <= '0;
         p_seg <= '0;
         p_an  <= '0;
      end else begin
         s_seg <= seg;
         s_an  <= an;
         p_seg <= s_seg;
         p_an  <= s_an;
      end
   end

   assign same = ({s_seg, s_an} == {p_seg, p_an});

   always_comb begin
      capturable = 1'b1;
      sel        = 2'd0;
      case (s_an)
         4'b1110: sel = 2'd0;
         4'b1101: sel = 2'd1;
         4'b1011: sel = 2'd2;
         4'b0111: sel = 2'd3;
         default: capturable = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stab_cnt <= '0;
      else if (!capturable || !same)
         stab_cnt <= '0;
      else if (stab_cnt != 8'hFF)
         stab_cnt <= stab_cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= WAIT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         WAIT:    if (capture) state_nx = HELD;
         HELD:    if (!same)   state_nx = WAIT;
         default: state_nx = WAIT;
      endcase
   end

   // Capture on the edge where the counter reaches STABLE_CYCLES-1
   always_comb begin
      capture = (state == WAIT) && same && capturable && (stab_cnt >= CAP_AT);
   end

   always_comb begin
      code     = 4'd0;
      is_blank = 1'b0;
      is_bad   = 1'b0;
      case (s_seg[6:0])
         7'h40:   code = 4'd0;
         7'h79:   code = 4'd1;
         7'h24:   code = 4'd2;
         7'h30:   code = 4'd3;
         7'h19:   code = 4'd4;
         7'h12:   code = 4'd5;
         7'h02:   code = 4'd6;
         7'h78:   code = 4'd7;
         7'h00:   code = 4'd8;
         7'h10:   code = 4'd9;
         7'h7F:   is_blank = 1'b1;
         default: is_bad = 1'b1;
      endcase
   end

   assign new_bit   = capture ? (4'b0001 << sel) : 4'b0000;
   assign complete  = (seen == 4'hF);
   assign cap_fills = capture && ((seen | new_bit) == 4'hF);
   assign tmr_inc   = {1'b0, timer} + 1'b1;
   // A capture that fills the frame on the expiry edge takes priority
   assign expire    = (seen != 4'h0) && !complete && (tmr_inc >= TLIM) && !cap_fills;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits      <= '0;
         dp_o        <= '0;
         blank       <= '0;
         bad         <= '0;
         frame_valid <= 1'b0;
         frame_count <= '0;
         timeout_err <= 1'b0;
         seen        <= '0;
         timer       <= '0;
         sh_digits   <= '0;
         sh_dp       <= '0;
         sh_blank    <= '0;
         sh_bad      <= '0;
      end else begin
         frame_valid <= complete;
         timeout_err <= expire;
         if (capture) begin
            sh_digits[4*sel +: 4] <= code;
            sh_dp[sel]            <= ~s_seg[7];
            sh_blank[sel]         <= is_blank;
            sh_bad[sel]           <= is_bad;
         end
         if (complete) begin
            digits      <= sh_digits;
            dp_o        <= sh_dp;
            blank       <= sh_blank;
            bad         <= sh_bad;
            frame_count <= frame_count + 8'd1;
            seen        <= new_bit;
            timer       <= '0;
         end else if (expire) begin
            seen  <= '0;
            timer <= '0;
         end else begin
            seen  <= seen | new_bit;
            timer <= (seen == 4'h0) ? '0 : timer + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed checks of seg_scan_decoder against a segment-level reference model.
module tb_seg_scan_decoder;

   localparam int SC = 4;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  seg = 8'hFF;
   logic [3:0]  an = 4'hF;
   logic [15:0] digits;
   logic [3:0]  dp_o, blank, bad;
   logic        frame_valid, timeout_err;
   logic [7:0]  frame_count;

   seg_scan_decoder #(.STABLE_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
      .digits(digits), .dp_o(dp_o), .blank(blank), .bad(bad),
      .frame_valid(frame_valid), .frame_count(frame_count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int fv_cnt = 0, to_cnt = 0;

   logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Reference model state: pending captures, frame in progress, displayed frame
   int         cq_edge[$];
   int         cq_idx[$];
   logic [7:0] cq_seg[$];
   logic [3:0] m_seen;
   int         m_fstart, fv_edge, m_count;
   logic [3:0] m_sh_code[4], m_o_code[4];
   logic       m_sh_dp[4], m_sh_blank[4], m_sh_bad[4];
   logic       m_o_dp[4], m_o_blank[4], m_o_bad[4];
   logic       exp_fv, exp_to;
   logic [11:0] prev_key;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int low_idx(input logic [3:0] a);
      int r = -1;
      if ($countones(a) == 3)
         for (int i = 0; i < 4; i++) if (!a[i]) r = i;
      return r;
   endfunction

   task automatic model_clear();
      cq_edge.delete(); cq_idx.delete(); cq_seg.delete();
      m_seen = 0; m_fstart = 0; fv_edge = -1; m_count = 0;
      exp_fv = 0; exp_to = 0; prev_key = 12'h000;
      for (int i = 0; i < 4; i++) begin
         m_sh_code[i] = 0; m_sh_dp[i] = 0; m_sh_blank[i] = 0; m_sh_bad[i] = 0;
         m_o_code[i] = 0; m_o_dp[i] = 0; m_o_blank[i] = 0; m_o_bad[i] = 0;
      end
   endtask

   task automatic model_store(input int idx, input logic [7:0] sg);
      m_sh_code[idx] = 0; m_sh_blank[idx] = 0; m_sh_bad[idx] = 1;
      m_sh_dp[idx] = ~sg[7];
      if (sg[6:0] == 7'h7F) begin
         m_sh_blank[idx] = 1; m_sh_bad[idx] = 0;
      end
      for (int k = 0; k < 10; k++)
         if (tbl[k] == sg[6:0]) begin
            m_sh_code[idx] = 4'(k); m_sh_bad[idx] = 0;
         end
   endtask

   task automatic model_edge(input int n);
      logic [3:0] bitm;
      exp_fv = 0; exp_to = 0;
      if (fv_edge == n) begin
         for (int i = 0; i < 4; i++) begin
            m_o_code[i] = m_sh_code[i]; m_o_dp[i] = m_sh_dp[i];
            m_o_blank[i] = m_sh_blank[i]; m_o_bad[i] = m_sh_bad[i];
         end
         m_count = (m_count + 1) % 256;
         exp_fv = 1; fv_edge = -1;
      end
      if (cq_edge.size() > 0 && cq_edge[0] == n) begin
         bitm = 4'(1 << cq_idx[0]);
         if (m_seen != 0 && n == m_fstart + TO && (m_seen | bitm) != 4'hF) begin
            exp_to = 1; m_seen = 0;
         end else begin
            model_store(cq_idx[0], cq_seg[0]);
            if (m_seen == 0) m_fstart = n;
            m_seen = m_seen | bitm;
            if (m_seen == 4'hF) begin
               fv_edge = n + 1; m_seen = 0;
            end
         end
         void'(cq_edge.pop_front()); void'(cq_idx.pop_front()); void'(cq_seg.pop_front());
      end else if (m_seen != 0 && n == m_fstart + TO) begin
         exp_to = 1; m_seen = 0;
      end
   endtask

   task automatic check_cycle();
      logic [15:0] ed;
      logic [3:0]  edp, ebl, ebd;
      for (int i = 0; i < 4; i++) begin
         ed[4*i +: 4] = m_o_code[i];
         edp[i] = m_o_dp[i]; ebl[i] = m_o_blank[i]; ebd[i] = m_o_bad[i];
      end
      if (frame_valid === 1'b1) fv_cnt++;
      if (timeout_err === 1'b1) to_cnt++;
      check("frame_valid", 32'(frame_valid), 32'(exp_fv));
      check("timeout_err", 32'(timeout_err), 32'(exp_to));
      check("digits", 32'(digits), 32'(ed));
      check("dp_o", 32'(dp_o), 32'(edp));
      check("blank", 32'(blank), 32'(ebl));
      check("bad", 32'(bad), 32'(ebd));
      check("frame_count", 32'(frame_count), 32'(m_count));
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge(cyc);
      #1;
      check_cycle();
   endtask

   task automatic run_seg(input logic [7:0] sg, input logic [3:0] a, input int d);
      int idx = low_idx(a);
      if ({sg, a} == prev_key && idx >= 0) begin
         an = 4'hF;
         step();
      end
      seg = sg; an = a;
      if (idx >= 0 && d >= SC) begin
         cq_edge.push_back(cyc + 1 + SC); cq_idx.push_back(idx); cq_seg.push_back(sg);
      end
      prev_key = {sg, a};
      repeat (d) step();
   endtask

   task automatic scan4(input int d0, input int d1, input int d2, input int d3, input int dwell);
      run_seg({1'b1, tbl[d0]}, 4'b1110, dwell);
      run_seg({1'b1, tbl[d1]}, 4'b1101, dwell);
      run_seg({1'b1, tbl[d2]}, 4'b1011, dwell);
      run_seg({1'b1, tbl[d3]}, 4'b0111, dwell);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_cycle();
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_digits", 32'(digits), 32'd0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int f0, t0;
      logic [7:0] c0;
      logic [7:0] rs;
      logic [3:0] ra;
      int         sel_r;

      model_clear();
      #1;
      check("reset_digits", 32'(digits), 32'd0);
      check("reset_fv", 32'(frame_valid), 32'd0);
      repeat (3) step();
      rst_n = 1'b1;
      run_seg(8'hFF, 4'hF, 3);

      // Basic scan 1,2,3,4
      f0 = fv_cnt;
      scan4(1, 2, 3, 4, 10);
      run_seg(8'hFF, 4'hF, 3);
      check("scan_pulses", 32'(fv_cnt - f0), 32'd1);
      check("scan_digits", 32'(digits), 32'h4321);
      check("scan_count", 32'(frame_count), 32'd1);
      check("scan_blank", 32'(blank), 32'd0);
      check("scan_bad", 32'(bad), 32'd0);

      // Dwell just short of capture, then exactly enough
      f0 = fv_cnt;
      scan4(5, 6, 7, 8, SC - 1);
      run_seg(8'hFF, 4'hF, 3);
      check("short_dwell_pulses", 32'(fv_cnt - f0), 32'd0);
      check("short_dwell_digits", 32'(digits), 32'h4321);
      scan4(5, 6, 7, 8, SC);
      run_seg(8'hFF, 4'hF, 3);
      check("exact_dwell_pulses", 32'(fv_cnt - f0), 32'd1);
      check("exact_dwell_digits", 32'(digits), 32'h8765);

      // Blank, bad pattern and decimal point
      run_seg({1'b0, tbl[5]}, 4'b1110, 8);
      run_seg(8'hDA, 4'b1101, 8);
      run_seg(8'hFF, 4'b1011, 8);
      run_seg({1'b1, tbl[8]}, 4'b0111, 8);
      run_seg(8'hFF, 4'hF, 3);
      check("flags_blank", 32'(blank), 32'b0100);
      check("flags_bad", 32'(bad), 32'b0010);
      check("flags_dp", 32'(dp_o), 32'b0001);
      check("flags_digits", 32'(digits), 32'h8005);

      // Multi-low anodes, then an incomplete frame that must time out
      f0 = fv_cnt; t0 = to_cnt;
      run_seg({1'b1, tbl[7]}, 4'b0011, 20);
      check("multilow_seen", 32'(dut.seen), 32'd0);
      run_seg({1'b1, tbl[1]}, 4'b1110, 10);
      run_seg({1'b1, tbl[2]}, 4'b1101, 10);
      run_seg({1'b1, tbl[3]}, 4'b1011, 10);
      run_seg(8'hFF, 4'hF, TO);
      check("timeout_pulses", 32'(to_cnt - t0), 32'd1);
      check("timeout_no_frame", 32'(fv_cnt - f0), 32'd0);
      check("timeout_digits", 32'(digits), 32'h8005);

      // Frame counter wrap
      f0 = fv_cnt; c0 = frame_count;
      for (int i = 0; i < 256; i++) scan4(i % 10, (i + 3) % 10, (i + 5) % 10, (i + 7) % 10, SC);
      run_seg(8'hFF, 4'hF, 3);
      check("wrap_pulses", 32'(fv_cnt - f0), 32'd256);
      check("wrap_count", 32'(frame_count), 32'(c0));

      // Reset between second and third digit
      run_seg({1'b1, tbl[9]}, 4'b1110, 6);
      run_seg({1'b1, tbl[8]}, 4'b1101, 6);
      run_seg({1'b1, tbl[7]}, 4'b1011, 2);
      do_reset();
      run_seg({1'b1, tbl[7]}, 4'b1011, 6);
      f0 = fv_cnt;
      scan4(2, 4, 6, 8, 7);
      run_seg(8'hFF, 4'hF, 3);
      check("post_reset_pulses", 32'(fv_cnt - f0), 32'd1);
      check("post_reset_digits", 32'(digits), 32'h8642);
      check("post_reset_count", 32'(frame_count), 32'd1);

      // Random scans, including noise and occasional long gaps
      for (int i = 0; i < 500; i++) begin
         sel_r = int'($urandom_range(0, 99));
         if (sel_r < 70) ra = ~(4'b0001 << $urandom_range(0, 3));
         else if (sel_r < 85) ra = 4'hF;
         else ra = 4'($urandom);
         sel_r = int'($urandom_range(0, 99));
         if (sel_r < 60) rs = {1'($urandom), tbl[$urandom_range(0, 9)]};
         else if (sel_r < 75) rs = {1'($urandom), 7'h7F};
         else rs = 8'($urandom);
         if ($urandom_range(0, 99) < 3) run_seg(8'hFF, 4'hF, int'($urandom_range(60, 120)));
         else run_seg(rs, ra, int'($urandom_range(1, 12)));
      end
      run_seg(8'hFF, 4'hF, TO + 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
